// File: rtl/ibex_pmp_chk_arbiter.sv
// Purpose: round-robin share of one PMP checking channel between NumReq requesters.
// Latency: accept at T, result valid at T+2 (each cfg_update_i pulse in CHECK adds a cycle).
// Backpressure: one check in flight; req_ready_o only in IDLE, rsp_valid_o held until rsp_ready_i.
//
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   req_valid_i/req_ready_o            per-requester request handshake (ready one-hot or zero)
//   req_addr_i/req_type_i/req_priv_i   per-requester check fields, sampled on the accept edge
//   rsp_valid_o/rsp_ready_i            per-requester result handshake (valid one-hot or zero)
//   rsp_err_o, rsp_enc_o               captured fault / encrypt attribute
//   pmp_req_addr_o/type_o, pmp_priv_o  registered request towards the PMP channel
//   pmp_req_err_i, pmp_enc_i           PMP result, combinational from pmp_*_o
//   cfg_update_i                       pmpcfg/pmpaddr write takes effect this cycle
//   busy_o                             a check is in flight (CHECK or RESP)

package ibex_pkg;
  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    PRIV_LVL_M = 2'b11,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_U = 2'b00
  } priv_lvl_e;
endpackage

module ibex_pmp_chk_arbiter #(
  parameter int unsigned NumReq  = 3,
  parameter int unsigned ReqIdxW = $clog2(NumReq)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                [NumReq-1:0]     req_valid_i,
  output logic                [NumReq-1:0]     req_ready_o,
  input  logic                [NumReq-1:0][33:0] req_addr_i,
  input  ibex_pkg::pmp_req_e  [NumReq-1:0]     req_type_i,
  input  ibex_pkg::priv_lvl_e [NumReq-1:0]     req_priv_i,
  output logic                [NumReq-1:0]     rsp_valid_o,
  input  logic                [NumReq-1:0]     rsp_ready_i,
  output logic                                 rsp_err_o,
  output logic                                 rsp_enc_o,
  output logic                [33:0]           pmp_req_addr_o,
  output ibex_pkg::pmp_req_e                   pmp_req_type_o,
  output ibex_pkg::priv_lvl_e                  pmp_priv_o,
  input  logic                                 pmp_req_err_i,
  input  logic                                 pmp_enc_i,
  input  logic                                 cfg_update_i,
  output logic                                 busy_o
);

  localparam int unsigned SumW = ReqIdxW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    RESP  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [ReqIdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ReqIdxW-1:0]  gnt_idx_q, gnt_idx_d;
  logic [33:0]         addr_q, addr_d;
  ibex_pkg::pmp_req_e  type_q, type_d;
  ibex_pkg::priv_lvl_e priv_q, priv_d;
  logic                err_q, err_d;
  logic                enc_q, enc_d;

  logic                gnt_found;
  logic [ReqIdxW-1:0]  gnt_sel;
  logic [SumW-1:0]     cand_sum;

  // Search upward from rr_ptr with wrap; NumReq need not be a power of two,
  // so the wrap is an explicit subtract rather than a truncation.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = '0;
    cand_sum  = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand_sum = SumW'(rr_ptr_q) + SumW'(i);
      if (cand_sum >= SumW'(NumReq)) begin
        cand_sum = cand_sum - SumW'(NumReq);
      end
      if (!gnt_found && req_valid_i[cand_sum[ReqIdxW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_sel   = cand_sum[ReqIdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    addr_d      = addr_q;
    type_d      = type_q;
    priv_d      = priv_q;
    err_d       = err_q;
    enc_d       = enc_q;
    req_ready_o = '0;
    rsp_valid_o = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready_o[gnt_sel] = 1'b1;
          addr_d    = req_addr_i[gnt_sel];
          type_d    = req_type_i[gnt_sel];
          priv_d    = req_priv_i[gnt_sel];
          gnt_idx_d = gnt_sel;
          rr_ptr_d  = (gnt_sel == ReqIdxW'(NumReq - 1)) ? '0 : gnt_sel + ReqIdxW'(1);
          state_d   = CHECK;
        end
      end
      CHECK: begin
        // A config write landing this cycle makes the PMP result stale:
        // wait a cycle and sample again against the new configuration.
        if (!cfg_update_i) begin
          err_d   = pmp_req_err_i;
          enc_d   = pmp_enc_i;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[gnt_idx_q] = 1'b1;
        if (rsp_ready_i[gnt_idx_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      addr_q    <= '0;
      type_q    <= ibex_pkg::PMP_ACC_READ;
      priv_q    <= ibex_pkg::PRIV_LVL_U;
      err_q     <= 1'b0;
      enc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      priv_q    <= priv_d;
      err_q     <= err_d;
      enc_q     <= enc_d;
    end
  end

  assign pmp_req_addr_o = addr_q;
  assign pmp_req_type_o = type_q;
  assign pmp_priv_o     = priv_q;
  assign rsp_err_o      = err_q;
  assign rsp_enc_o      = enc_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_pmp_chk_arbiter.sv
// Purpose: directed self-checking bench for ibex_pmp_chk_arbiter (NumReq=3).
// Latency: inputs driven 1 time unit after posedge, outputs checked 1 unit later.
// Backpressure: rsp_ready_i driven per test to exercise held responses.
module tb_ibex_pmp_chk_arbiter;

  logic                               clk_i;
  logic                               rst_i;
  logic                [2:0]          req_valid_i;
  logic                [2:0]          req_ready_o;
  logic                [2:0][33:0]    req_addr_i;
  ibex_pkg::pmp_req_e  [2:0]          req_type_i;
  ibex_pkg::priv_lvl_e [2:0]          req_priv_i;
  logic                [2:0]          rsp_valid_o;
  logic                [2:0]          rsp_ready_i;
  logic                               rsp_err_o;
  logic                               rsp_enc_o;
  logic                [33:0]         pmp_req_addr_o;
  ibex_pkg::pmp_req_e                 pmp_req_type_o;
  ibex_pkg::priv_lvl_e                pmp_priv_o;
  logic                               pmp_req_err_i;
  logic                               pmp_enc_i;
  logic                               cfg_update_i;
  logic                               busy_o;

  int n_checks = 0;
  int n_errors = 0;

  ibex_pmp_chk_arbiter #(.NumReq(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_type_i     (req_type_i),
    .req_priv_i     (req_priv_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_err_o      (rsp_err_o),
    .rsp_enc_o      (rsp_enc_o),
    .pmp_req_addr_o (pmp_req_addr_o),
    .pmp_req_type_o (pmp_req_type_o),
    .pmp_priv_o     (pmp_priv_o),
    .pmp_req_err_i  (pmp_req_err_i),
    .pmp_enc_i      (pmp_enc_i),
    .cfg_update_i   (cfg_update_i),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [2:0] rr_exp [12];

    rst_i         = 1'b1;
    req_valid_i   = '0;
    rsp_ready_i   = '0;
    cfg_update_i  = 1'b0;
    pmp_req_err_i = 1'b0;
    pmp_enc_i     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr_i[i] = 34'(i + 1) << 12;
      req_type_i[i] = ibex_pkg::PMP_ACC_READ;
      req_priv_i[i] = ibex_pkg::PRIV_LVL_U;
    end

    // ---- reset state
    #2;
    chk("rst_busy",  64'(busy_o), 64'h0);
    chk("rst_ready", 64'(req_ready_o), 64'h0);
    chk("rst_rspv",  64'(rsp_valid_o), 64'h0);
    chk("rst_addr",  64'(pmp_req_addr_o), 64'h0);
    chk("rst_type",  64'(pmp_req_type_o), 64'(ibex_pkg::PMP_ACC_READ));
    chk("rst_priv",  64'(pmp_priv_o), 64'(ibex_pkg::PRIV_LVL_U));
    chk("rst_err",   64'({rsp_err_o, rsp_enc_o}), 64'h0);
    tick();
    rst_i = 1'b0;
    tick();

    // ---- single request from req0, PMP reports a fault
    req_valid_i    = 3'b001;
    req_addr_i[0]  = 34'h0_8000_0000;
    req_type_i[0]  = ibex_pkg::PMP_ACC_READ;
    req_priv_i[0]  = ibex_pkg::PRIV_LVL_U;
    #1;
    chk("single_ready_T", 64'(req_ready_o), 64'h1);
    chk("single_busy_T",  64'(busy_o), 64'h0);
    tick();
    req_valid_i   = '0;
    req_addr_i[0] = 34'h1_2345_6789;
    pmp_req_err_i = 1'b1;
    #1;
    chk("single_addr_T1",  64'(pmp_req_addr_o), 64'h0_8000_0000);
    chk("single_busy_T1",  64'(busy_o), 64'h1);
    chk("single_rspv_T1",  64'(rsp_valid_o), 64'h0);
    tick();
    pmp_req_err_i = 1'b0;
    rsp_ready_i   = 3'b001;
    #1;
    chk("single_rspv_T2", 64'(rsp_valid_o), 64'h1);
    chk("single_err_T2",  64'(rsp_err_o), 64'h1);
    tick();
    rsp_ready_i = '0;
    #1;
    chk("single_idle_T3", 64'({busy_o, rsp_valid_o}), 64'h0);

    // ---- reset mid-RESP: rr_ptr is 1, so req1 is granted
    req_valid_i   = 3'b010;
    req_priv_i[1] = ibex_pkg::PRIV_LVL_M;
    #1;
    chk("rstr_ready", 64'(req_ready_o), 64'h2);
    tick();
    req_valid_i = '0;
    tick();
    #1;
    chk("rstr_rspv_pre", 64'(rsp_valid_o), 64'h2);
    chk("rstr_priv_pre", 64'(pmp_priv_o), 64'(ibex_pkg::PRIV_LVL_M));
    rst_i = 1'b1;
    #1;
    chk("rstr_rspv", 64'(rsp_valid_o), 64'h0);
    chk("rstr_busy", 64'(busy_o), 64'h0);
    chk("rstr_priv", 64'(pmp_priv_o), 64'(ibex_pkg::PRIV_LVL_U));
    tick();
    rst_i       = 1'b0;
    rsp_ready_i = 3'b111;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rstr_dropped", 64'({busy_o, rsp_valid_o}), 64'h0);
    end

    // ---- round robin, all valid, responses always accepted
    for (int c = 0; c < 12; c++) rr_exp[c] = 3'b000;
    rr_exp[0] = 3'b001;
    rr_exp[3] = 3'b010;
    rr_exp[6] = 3'b100;
    rr_exp[9] = 3'b001;
    for (int i = 0; i < 3; i++) begin
      req_addr_i[i] = 34'(i + 1) << 12;
      req_priv_i[i] = ibex_pkg::PRIV_LVL_U;
    end
    req_valid_i = 3'b111;
    for (int c = 0; c < 12; c++) begin
      if (c == 10) req_valid_i = '0;
      #1;
      chk($sformatf("rr_ready_c%0d", c), 64'(req_ready_o), 64'(rr_exp[c]));
      if (c == 7) chk("rr_addr_req2", 64'(pmp_req_addr_o), 64'h3000);
      tick();
    end
    // rr_ptr is now 1 and the FSM is idle

    // ---- wrap/skip: req1 alone moves rr_ptr to 2, then req0+req1
    req_valid_i = 3'b010;
    #1;
    chk("wrap_ready_a", 64'(req_ready_o), 64'h2);
    tick();
    req_valid_i = '0;
    tick();
    tick();
    req_valid_i = 3'b011;
    #1;
    chk("wrap_ready_b", 64'(req_ready_o), 64'h1);
    tick();
    req_valid_i = 3'b010;
    #1;
    chk("wrap_ready_b1", 64'(req_ready_o), 64'h0);
    tick();
    tick();
    #1;
    chk("wrap_ready_c", 64'(req_ready_o), 64'h2);
    tick();
    req_valid_i = '0;
    tick();
    tick();
    // rr_ptr is now 2

    // ---- config change during CHECK
    rsp_ready_i = '0;
    req_valid_i = 3'b100;
    #1;
    chk("cfg_ready_T", 64'(req_ready_o), 64'h4);
    tick();
    req_valid_i   = '0;
    cfg_update_i  = 1'b1;
    pmp_req_err_i = 1'b0;
    tick();
    cfg_update_i  = 1'b1;
    pmp_req_err_i = 1'b1;
    #1;
    chk("cfg_rspv_T2", 64'(rsp_valid_o), 64'h0);
    tick();
    cfg_update_i = 1'b0;
    #1;
    chk("cfg_rspv_T3", 64'(rsp_valid_o), 64'h0);
    chk("cfg_busy_T3", 64'(busy_o), 64'h1);
    tick();
    cfg_update_i  = 1'b1;
    pmp_req_err_i = 1'b0;
    rsp_ready_i   = 3'b100;
    #1;
    chk("cfg_rspv_T4", 64'(rsp_valid_o), 64'h4);
    chk("cfg_err_T4",  64'(rsp_err_o), 64'h1);
    tick();
    cfg_update_i = 1'b0;
    rsp_ready_i  = '0;
    #1;
    chk("cfg_idle_T5", 64'(busy_o), 64'h0);
    // rr_ptr is now 0

    // ---- backpressure on req2 with req0 waiting
    req_valid_i = 3'b100;
    #1;
    chk("bp_ready_U", 64'(req_ready_o), 64'h4);
    tick();
    req_valid_i   = 3'b001;
    pmp_req_err_i = 1'b1;
    pmp_enc_i     = 1'b1;
    tick();
    pmp_req_err_i = 1'b0;
    pmp_enc_i     = 1'b0;
    rsp_ready_i   = 3'b001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_rspv_c%0d", c), 64'(rsp_valid_o), 64'h4);
      chk($sformatf("bp_res_c%0d", c), 64'({rsp_err_o, rsp_enc_o}), 64'h3);
      chk($sformatf("bp_ready_c%0d", c), 64'(req_ready_o), 64'h0);
      tick();
    end
    rsp_ready_i = 3'b100;
    #1;
    chk("bp_rspv_rel", 64'(rsp_valid_o), 64'h4);
    chk("bp_ready_rel", 64'(req_ready_o), 64'h0);
    tick();
    rsp_ready_i = 3'b111;
    #1;
    chk("bp_ready_next", 64'(req_ready_o), 64'h1);
    tick();
    req_valid_i = '0;
    tick();
    tick();
    #1;
    chk("end_idle", 64'(busy_o), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
